// File: rtl/i2s_tx_frame_gen.sv
// Local-side I2S transmitter: divides the fabric clock into bit clock and
// word select, serializes stereo frames and exports a wrapping frame count.
module i2s_tx_frame_gen #(
    parameter int HALF_DIV   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    CLK_IP_i,
    input  logic                    RST_IP_n_i,
    input  logic                    enable_i,
    input  logic [2*DATA_WIDTH-1:0] sample_i,
    input  logic                    sample_valid_i,
    output logic                    sample_ready_o,
    input  logic                    underrun_clr_i,
    output logic                    bitclk_o,
    output logic                    ws_o,
    output logic                    sd_o,
    output logic                    frame_sync_o,
    output logic [CNT_WIDTH-1:0]    word_cnt_o,
    output logic                    underrun_o
);

    localparam int FW   = 2 * DATA_WIDTH;
    localparam int DV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int BC_W = $clog2(FW);

    localparam logic [DV_W-1:0] DIV_LAST = DV_W'(HALF_DIV - 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(FW - 1);
    localparam logic [BC_W-1:0] WS_LO    = BC_W'(DATA_WIDTH - 1);
    localparam logic [BC_W-1:0] WS_HI    = BC_W'(FW - 2);

    logic [DV_W-1:0]      r_div_cnt;
    logic                 r_bitclk;
    logic [BC_W-1:0]      r_bit_cnt;
    logic                 r_ws;
    logic [FW-1:0]        r_shift;
    logic [FW-1:0]        r_hold;
    logic                 r_hold_full;
    logic                 r_frame_sync;
    logic [CNT_WIDTH-1:0] r_word_cnt;
    logic                 r_underrun;

    logic                 w_term;
    logic                 w_fall;
    logic                 w_load;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_starve;
    logic [BC_W-1:0]      w_bit_nxt;
    logic [FW-1:0]        w_load_data;

    assign w_term    = (r_div_cnt == DIV_LAST);
    assign w_fall    = enable_i & w_term & r_bitclk;
    assign w_load    = w_fall & (r_bit_cnt == BIT_LAST);
    assign w_bit_nxt = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BC_W'(1);

    // Ready is masked by reset so every output reads zero while reset is held.
    assign w_ready  = enable_i & ~r_hold_full & RST_IP_n_i;
    assign w_accept = sample_valid_i & w_ready;
    assign w_starve = w_load & ~r_hold_full & ~sample_valid_i;

    always_comb begin
        w_load_data = '0;
        if (r_hold_full) begin
            w_load_data = r_hold;
        end else if (sample_valid_i) begin
            w_load_data = sample_i;
        end
    end

    always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
        if (!RST_IP_n_i) begin
            r_div_cnt    <= '0;
            r_bitclk     <= 1'b0;
            r_bit_cnt    <= BIT_LAST;
            r_ws         <= 1'b0;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_frame_sync <= 1'b0;
        end else if (!enable_i) begin
            r_div_cnt    <= '0;
            r_bitclk     <= 1'b0;
            r_bit_cnt    <= BIT_LAST;
            r_ws         <= 1'b0;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_frame_sync <= 1'b0;
        end else begin
            r_frame_sync <= w_load;
            if (w_term) begin
                r_div_cnt <= '0;
                r_bitclk  <= ~r_bitclk;
            end else begin
                r_div_cnt <= r_div_cnt + DV_W'(1);
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_ws      <= (w_bit_nxt >= WS_LO) && (w_bit_nxt <= WS_HI);
                if (w_load) begin
                    r_shift <= w_load_data;
                end else begin
                    r_shift <= {r_shift[FW-2:0], 1'b0};
                end
            end
            // A bypass accept during a load goes straight to the shifter.
            if (w_load) begin
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold      <= sample_i;
                r_hold_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
        if (!RST_IP_n_i) begin
            r_word_cnt <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
            end
            if (w_starve) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr_i) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign sample_ready_o = w_ready;
    assign bitclk_o       = r_bitclk;
    assign ws_o           = r_ws;
    assign sd_o           = r_shift[FW-1];
    assign frame_sync_o   = r_frame_sync;
    assign word_cnt_o     = r_word_cnt;
    assign underrun_o     = r_underrun;

endmodule

// File: tb/tb_i2s_tx_frame_gen.sv
// Randomized bench for i2s_tx_frame_gen against a cycle-count based
// reference model of the bit clock, frame timing and sample supply.
module tb_i2s_tx_frame_gen;

    localparam int H  = 2;
    localparam int DW = 16;
    localparam int FW = 2 * DW;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable_i;
    logic [FW-1:0] sample_i;
    logic          sample_valid_i;
    logic          sample_ready_o;
    logic          underrun_clr_i;
    logic          bitclk_o;
    logic          ws_o;
    logic          sd_o;
    logic          frame_sync_o;
    logic [CW-1:0] word_cnt_o;
    logic          underrun_o;

    i2s_tx_frame_gen #(
        .HALF_DIV   (H),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK_IP_i       (clk),
        .RST_IP_n_i     (rst_n),
        .enable_i       (enable_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .underrun_clr_i (underrun_clr_i),
        .bitclk_o       (bitclk_o),
        .ws_o           (ws_o),
        .sd_o           (sd_o),
        .frame_sync_o   (frame_sync_o),
        .word_cnt_o     (word_cnt_o),
        .underrun_o     (underrun_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: n = enabled edges since enable rose; falls every 2H edges.
    int            n    = 0;
    logic [FW-1:0] cur  = '0;
    logic [FW-1:0] q[$];
    int            m_wc = 0;
    logic          m_ur = 1'b0;
    logic          m_fs = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic load_at(input int nn);
        return (nn > 0) && (nn % (2 * H) == 0) &&
               (((nn / (2 * H)) - 1) % FW == 0);
    endfunction

    function automatic int cur_bit();
        int k;
        k = n / (2 * H);
        return (k > 0) ? (k - 1) % FW : -1;
    endfunction

    task automatic model_edge(input logic en, input logic v,
                              input logic [FW-1:0] d, input logic c);
        logic starve;
        starve = 1'b0;
        m_fs   = 1'b0;
        if (!en) begin
            n = 0;
            q.delete();
        end else begin
            n++;
            if (load_at(n)) begin
                if (q.size() > 0) begin
                    cur = q.pop_front();
                end else if (v) begin
                    cur = d;
                end else begin
                    cur    = '0;
                    starve = 1'b1;
                end
                m_fs = 1'b1;
                m_wc = (m_wc + 1) % (1 << CW);
            end else if (v && q.size() == 0) begin
                q.push_back(d);
            end
        end
        if (starve) m_ur = 1'b1;
        else if (c) m_ur = 1'b0;
    endtask

    task automatic chk_out();
        int   b;
        logic e_ws;
        logic e_sd;
        b    = cur_bit();
        e_ws = (b >= DW - 1) && (b <= FW - 2);
        e_sd = (b >= 0) ? cur[FW-1-b] : 1'b0;
        chk("bitclk", 32'(bitclk_o), 32'((n / H) % 2));
        chk("ws", 32'(ws_o), 32'(e_ws));
        chk("sd", 32'(sd_o), 32'(e_sd));
        chk("fsync", 32'(frame_sync_o), 32'(m_fs));
        chk("wcnt", 32'(word_cnt_o), 32'(m_wc));
        chk("underrun", 32'(underrun_o), 32'(m_ur));
    endtask

    task automatic cyc(input logic en, input logic v,
                       input logic [FW-1:0] d, input logic c);
        enable_i       = en;
        sample_valid_i = v;
        sample_i       = d;
        underrun_clr_i = c;
        #1;
        chk("ready", 32'(sample_ready_o), 32'(en && q.size() == 0));
        model_edge(en, v, d, c);
        @(posedge clk);
        #1;
        chk_out();
    endtask

    task automatic idle_to_load();
        int i;
        for (i = 0; i < 300 && !load_at(n + 1); i++) cyc(1'b1, 1'b0, '0, 1'b0);
        chk("load_reach", 32'(load_at(n + 1)), 32'd1);
    endtask

    task automatic rand_cyc();
        logic v;
        v = (q.size() == 0) ? ($urandom_range(0, 3) != 0)
                            : ($urandom_range(0, 1) == 1);
        cyc(1'b1, v, FW'($urandom), $urandom_range(0, 31) == 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        enable_i       = 1'b0;
        sample_i       = '0;
        sample_valid_i = 1'b0;
        underrun_clr_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(sample_ready_o), 32'd0);
        chk_out();
        rst_n = 1'b1;

        // Sample offered as enable rises, then left idle.
        cyc(1'b1, 1'b1, 32'hA55A0F0F, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b0);
        chk("first_load_fs", 32'(frame_sync_o), 32'd1);
        chk("first_load_wc", 32'(word_cnt_o), 32'd1);
        chk("first_load_ws", 32'(ws_o), 32'd0);

        // Next frame starves; clear later; then clear coinciding with starve.
        idle_to_load();
        cyc(1'b1, 1'b0, '0, 1'b0);
        chk("ur_set", 32'(underrun_o), 32'd1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b1);
        chk("ur_clr", 32'(underrun_o), 32'd0);
        idle_to_load();
        cyc(1'b1, 1'b0, '0, 1'b1);
        chk("ur_prio", 32'(underrun_o), 32'd1);
        cyc(1'b1, 1'b0, '0, 1'b1);

        // Bypass: valid only in the load cycle.
        idle_to_load();
        cyc(1'b1, 1'b1, 32'h12345678, 1'b0);
        chk("byp_ready", 32'(sample_ready_o), 32'd1);
        chk("byp_ur", 32'(underrun_o), 32'd0);

        // Randomized streaming.
        for (int i = 0; i < 20 * FW * 2 * H; i++) rand_cyc();

        // Disable at bit 7, then re-enable.
        for (int i = 0; i < 300 && cur_bit() != 7; i++) rand_cyc();
        chk("bit7_reach", 32'(cur_bit()), 32'd7);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("dis_bclk", 32'(bitclk_o), 32'd0);
        repeat ($urandom_range(1, 5)) cyc(1'b0, 1'($urandom), FW'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, '0, 1'b0);
        chk("reen_fs", 32'(frame_sync_o), 32'd1);
        chk("reen_ws", 32'(ws_o), 32'd0);

        for (int i = 0; i < 6 * FW * 2 * H; i++) rand_cyc();

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 300 && cur_bit() != 11; i++) rand_cyc();
        enable_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n    = 0;
        cur  = '0;
        q.delete();
        m_wc = 0;
        m_ur = 1'b0;
        m_fs = 1'b0;
        chk("arst_ready", 32'(sample_ready_o), 32'd0);
        chk_out();
        @(posedge clk);
        #1;
        chk_out();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FW * 2 * H; i++) rand_cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
